// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: ALU control encodings,
// MIPS opcode/funct constants, FSM state encoding and operand-select enums.
// Optional feature macro: ALU_ISSUE_MUL_EN (enables the mul decode).
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_SLT = 4'b0010,
      ALU_AND = 4'b0011,
      ALU_OR  = 4'b0100,
      ALU_NOR = 4'b0101,
      ALU_XOR = 4'b0110,
      ALU_SLL = 4'b0111,
      ALU_SRL = 4'b1000,
      ALU_MUL = 4'b1001
   } aluCtrl_e;

   localparam logic [5:0] OP_RTYPE    = 6'h00;
   localparam logic [5:0] OP_ADDI     = 6'h08;
   localparam logic [5:0] OP_SLTI     = 6'h0A;
   localparam logic [5:0] OP_ANDI     = 6'h0C;
   localparam logic [5:0] OP_ORI      = 6'h0D;
   localparam logic [5:0] OP_XORI     = 6'h0E;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;
   localparam logic [5:0] FN_MUL = 6'h02;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      A_ZERO  = 2'd0,
      A_RS    = 2'd1,
      A_SHAMT = 2'd2
   } aSel_e;

   typedef enum logic [1:0] {
      B_ZERO = 2'd0,
      B_RT   = 2'd1,
      B_IMM  = 2'd2
   } bSel_e;

   typedef enum logic {
      EXT_ZERO = 1'b0,
      EXT_SIGN = 1'b1
   } extMode_e;

   // Widen a 16-bit immediate according to the decoded extension mode
   function automatic logic [31:0] extendImm(input logic [15:0] imm, input extMode_e mode);
      if (mode == EXT_SIGN) begin
         return {{16{imm[15]}}, imm};
      end
      return {16'h0000, imm};
   endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Bundle of the issue-unit handshake, operand, ALU and result signals.
// The slave modport is the issue unit's view; master is the environment's.
interface alu_issue_unit_if;

   logic        InValid;
   logic        InReady;
   logic [31:0] Instr;
   logic [31:0] RsData;
   logic [31:0] RtData;
   logic [3:0]  AluCtrl;
   logic [31:0] AluA;
   logic [31:0] AluB;
   logic [31:0] AluResult;
   logic        AluZero;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] Result;
   logic        ZeroFlag;
   logic [4:0]  DestReg;
   logic        Illegal;

   modport slave (
      input  InValid, Instr, RsData, RtData, AluResult, AluZero, OutReady,
      output InReady, AluCtrl, AluA, AluB, OutValid, Result, ZeroFlag, DestReg, Illegal
   );

   modport master (
      output InValid, Instr, RsData, RtData, AluResult, AluZero, OutReady,
      input  InReady, AluCtrl, AluA, AluB, OutValid, Result, ZeroFlag, DestReg, Illegal
   );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Purely combinational MIPS decode: instruction word to ALU control,
// operand selects, immediate extension mode, destination and illegal flag.
// Optional feature macro: ALU_ISSUE_MUL_EN (opcode 0x1C funct 0x02 -> mul).
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output aluCtrl_e    aluCtrl,
   output aSel_e       aSel,
   output bSel_e       bSel,
   output extMode_e    extMode,
   output logic [4:0]  destReg,
   output logic        illegal
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rtField;
   logic [4:0] rdField;
   logic       rType;
   logic       iType;
   logic       shiftOp;
   logic       unusedFields;

   assign opcode  = instr[31:26];
   assign funct   = instr[5:0];
   assign rtField = instr[20:16];
   assign rdField = instr[15:11];

   // rs and shamt are consumed as data by the issue unit, not by decode
   assign unusedFields = ^{instr[25:21], instr[10:6]};

   // Classify the encoding and pick the ALU operation; anything unmatched stays illegal
   always_comb begin
      aluCtrl = ALU_ADD;
      extMode = EXT_ZERO;
      rType   = 1'b0;
      iType   = 1'b0;
      shiftOp = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD: begin aluCtrl = ALU_ADD; rType = 1'b1; end
               FN_SUB: begin aluCtrl = ALU_SUB; rType = 1'b1; end
               FN_SLT: begin aluCtrl = ALU_SLT; rType = 1'b1; end
               FN_AND: begin aluCtrl = ALU_AND; rType = 1'b1; end
               FN_OR:  begin aluCtrl = ALU_OR;  rType = 1'b1; end
               FN_NOR: begin aluCtrl = ALU_NOR; rType = 1'b1; end
               FN_XOR: begin aluCtrl = ALU_XOR; rType = 1'b1; end
               FN_SLL: begin aluCtrl = ALU_SLL; rType = 1'b1; shiftOp = 1'b1; end
               FN_SRL: begin aluCtrl = ALU_SRL; rType = 1'b1; shiftOp = 1'b1; end
               default: begin end
            endcase
         end
         OP_ADDI: begin aluCtrl = ALU_ADD; iType = 1'b1; extMode = EXT_SIGN; end
         OP_SLTI: begin aluCtrl = ALU_SLT; iType = 1'b1; extMode = EXT_SIGN; end
         OP_ANDI: begin aluCtrl = ALU_AND; iType = 1'b1; end
         OP_ORI:  begin aluCtrl = ALU_OR;  iType = 1'b1; end
         OP_XORI: begin aluCtrl = ALU_XOR; iType = 1'b1; end
`ifdef ALU_ISSUE_MUL_EN
         OP_SPECIAL2: begin
            if (funct == FN_MUL) begin
               aluCtrl = ALU_MUL;
               rType   = 1'b1;
            end
         end
`else
         OP_SPECIAL2: begin end
`endif
         default: begin end
      endcase
   end

   // Route operands and destination from the instruction class; illegal zeroes everything
   always_comb begin
      illegal = ~(rType | iType);
      aSel    = A_ZERO;
      bSel    = B_ZERO;
      destReg = 5'd0;
      if (rType) begin
         aSel    = shiftOp ? A_SHAMT : A_RS;
         bSel    = B_RT;
         destReg = rdField;
      end else if (iType) begin
         aSel    = A_RS;
         bSel    = B_IMM;
         destReg = rtField;
      end
   end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue unit: accepts one instruction plus operands, presents it to an
// external ALU for exactly one cycle, then holds the captured result until
// the consumer takes it. IDLE -> EXEC -> HOLD -> IDLE.
// Optional feature macro: ALU_ISSUE_MUL_EN (enables the mul decode).
module alu_issue_unit
   import alu_pkg::*;
(
   input logic             Clk,
   input logic             Reset,
   alu_issue_unit_if.slave bus
);

   state_e      state;
   logic [31:0] instrReg;
   logic [31:0] rsReg;
   logic [31:0] rtReg;
   logic        inReadyReg;
   logic        outValidReg;
   logic [31:0] resultReg;
   logic        zeroReg;
   logic [4:0]  destRegQ;
   logic        illegalReg;

   aluCtrl_e    decCtrl;
   aSel_e       decASel;
   bSel_e       decBSel;
   extMode_e    decExt;
   logic [4:0]  decDest;
   logic        decIllegal;

   logic [31:0] opA;
   logic [31:0] opB;

   alu_ctrl_decode uDecode (
      .instr   (instrReg),
      .aluCtrl (decCtrl),
      .aSel    (decASel),
      .bSel    (decBSel),
      .extMode (decExt),
      .destReg (decDest),
      .illegal (decIllegal)
   );

   // Build ALU operands from the held instruction and operands only
   always_comb begin
      opA = 32'd0;
      opB = 32'd0;
      case (decASel)
         A_RS:    opA = rsReg;
         A_SHAMT: opA = {27'd0, instrReg[10:6]};
         default: opA = 32'd0;
      endcase
      case (decBSel)
         B_RT:    opB = rtReg;
         B_IMM:   opB = extendImm(instrReg[15:0], decExt);
         default: opB = 32'd0;
      endcase
   end

   assign bus.AluCtrl  = (state == ST_EXEC) ? decCtrl : ALU_ADD;
   assign bus.AluA     = (state == ST_EXEC) ? opA : 32'd0;
   assign bus.AluB     = (state == ST_EXEC) ? opB : 32'd0;
   assign bus.InReady  = inReadyReg;
   assign bus.OutValid = outValidReg;
   assign bus.Result   = resultReg;
   assign bus.ZeroFlag = zeroReg;
   assign bus.DestReg  = destRegQ;
   assign bus.Illegal  = illegalReg;

   // Sequencer: accept in IDLE, capture the ALU response in EXEC, hold until consumed
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= ST_IDLE;
         instrReg    <= 32'd0;
         rsReg       <= 32'd0;
         rtReg       <= 32'd0;
         inReadyReg  <= 1'b1;
         outValidReg <= 1'b0;
         resultReg   <= 32'd0;
         zeroReg     <= 1'b0;
         destRegQ    <= 5'd0;
         illegalReg  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.InValid) begin
                  instrReg   <= bus.Instr;
                  rsReg      <= bus.RsData;
                  rtReg      <= bus.RtData;
                  inReadyReg <= 1'b0;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               resultReg   <= decIllegal ? 32'd0 : bus.AluResult;
               zeroReg     <= decIllegal ? 1'b1 : bus.AluZero;
               destRegQ    <= decDest;
               illegalReg  <= decIllegal;
               outValidReg <= 1'b1;
               state       <= ST_HOLD;
            end
            ST_HOLD: begin
               if (bus.OutReady) begin
                  outValidReg <= 1'b0;
                  inReadyReg  <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               outValidReg <= 1'b0;
               inReadyReg  <= 1'b1;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit. The bench plays the external ALU,
// drives directed instructions, pushes the hand-computed expected response
// into a scoreboard queue, and a monitor pops/compares on each new OutValid.
module tb_alu_issue_unit;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] result;
      logic        zero;
      logic [4:0]  dest;
      logic        ill;
   } exp_t;

   logic Clk;
   logic Reset;

   alu_issue_unit_if bus ();

   alu_issue_unit dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   exp_t expQ[$];
   int   checkCount;
   int   passCount;

   logic [31:0] aluRes;
   logic [3:0]  seenCtrl;
   logic [31:0] seenA;
   logic [31:0] seenB;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural ALU sitting outside the issue unit
   always_comb begin
      case (bus.AluCtrl)
         4'd0:    aluRes = bus.AluA + bus.AluB;
         4'd1:    aluRes = bus.AluA - bus.AluB;
         4'd2:    aluRes = {31'd0, ($signed(bus.AluA) < $signed(bus.AluB))};
         4'd3:    aluRes = bus.AluA & bus.AluB;
         4'd4:    aluRes = bus.AluA | bus.AluB;
         4'd5:    aluRes = ~(bus.AluA | bus.AluB);
         4'd6:    aluRes = bus.AluA ^ bus.AluB;
         4'd7:    aluRes = bus.AluB << bus.AluA[4:0];
         4'd8:    aluRes = bus.AluB >> bus.AluA[4:0];
         4'd9:    aluRes = bus.AluA * bus.AluB;
         default: aluRes = 32'hDEADBEEF;
      endcase
   end

   assign bus.AluResult = aluRes;
   assign bus.AluZero   = (aluRes == 32'd0);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // One transaction: accept, check latency, optional backpressure or reset in HOLD, release
   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic zero, input logic [4:0] dest,
                                input logic ill, input int holdCycles, input bit resetInHold);
      exp_t e;
      int   n;
      n = 0;
      while (bus.InReady !== 1'b1 && n < 50) begin
         @(posedge Clk); #1;
         n++;
      end
      if (n == 50) checkOutput("inReadyTimeout", 32'd0, 32'd1);
      e.ctrl = ctrl; e.a = a; e.b = b; e.result = res; e.zero = zero; e.dest = dest; e.ill = ill;
      expQ.push_back(e);
      bus.InValid = 1'b1;
      bus.Instr   = instr;
      bus.RsData  = rs;
      bus.RtData  = rt;
      @(posedge Clk); #1;
      bus.InValid = 1'b0;
      bus.Instr   = 32'hFFFFFFFF;
      bus.RsData  = 32'hA5A5A5A5;
      bus.RtData  = 32'h5A5A5A5A;
      checkOutput("execInReady", {31'd0, bus.InReady}, 32'd0);
      checkOutput("execOutValid", {31'd0, bus.OutValid}, 32'd0);
      @(posedge Clk); #1;
      checkOutput("latencyOutValid", {31'd0, bus.OutValid}, 32'd1);
      if (resetInHold) begin
         @(negedge Clk); #1;
         Reset = 1'b1;
         #1;
         checkOutput("rstHoldOutValid", {31'd0, bus.OutValid}, 32'd0);
         checkOutput("rstHoldResult", bus.Result, 32'd0);
         checkOutput("rstHoldZero", {31'd0, bus.ZeroFlag}, 32'd0);
         checkOutput("rstHoldDest", {27'd0, bus.DestReg}, 32'd0);
         @(posedge Clk); #1;
         Reset = 1'b0;
         @(posedge Clk); #1;
         checkOutput("rstHoldInReady", {31'd0, bus.InReady}, 32'd1);
      end else begin
         for (int i = 0; i < holdCycles; i++) begin
            bus.InValid = 1'b1;
            bus.Instr   = 32'h00221822;
            @(posedge Clk); #1;
            checkOutput("bpOutValid", {31'd0, bus.OutValid}, 32'd1);
            checkOutput("bpResult", bus.Result, res);
            checkOutput("bpInReady", {31'd0, bus.InReady}, 32'd0);
         end
         bus.OutReady = 1'b1;
         @(posedge Clk); #1;
         bus.OutReady = 1'b0;
         bus.InValid  = 1'b0;
         checkOutput("releaseInReady", {31'd0, bus.InReady}, 32'd1);
         checkOutput("releaseOutValid", {31'd0, bus.OutValid}, 32'd0);
      end
   endtask

   // Monitor: note ALU ports during EXEC, score the held response on each new OutValid
   initial begin
      exp_t e;
      logic prevValid;
      prevValid = 1'b0;
      seenCtrl  = 4'd0;
      seenA     = 32'd0;
      seenB     = 32'd0;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            prevValid = 1'b0;
         end else begin
            if (!bus.InReady && !bus.OutValid) begin
               seenCtrl = bus.AluCtrl;
               seenA    = bus.AluA;
               seenB    = bus.AluB;
            end
            if (bus.OutValid && !prevValid) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpectedOutput", 32'd1, 32'd0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("aluCtrl", {28'd0, seenCtrl}, {28'd0, e.ctrl});
                  checkOutput("aluA", seenA, e.a);
                  checkOutput("aluB", seenB, e.b);
                  checkOutput("result", bus.Result, e.result);
                  checkOutput("zeroFlag", {31'd0, bus.ZeroFlag}, {31'd0, e.zero});
                  checkOutput("destReg", {27'd0, bus.DestReg}, {27'd0, e.dest});
                  checkOutput("illegal", {31'd0, bus.Illegal}, {31'd0, e.ill});
                  checkOutput("holdAluCtrlZero", {28'd0, bus.AluCtrl}, 32'd0);
                  checkOutput("holdAluAZero", bus.AluA, 32'd0);
               end
            end
            prevValid = bus.OutValid;
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence
   initial begin
      checkCount   = 0;
      passCount    = 0;
      Reset        = 1'b1;
      bus.InValid  = 1'b0;
      bus.Instr    = 32'd0;
      bus.RsData   = 32'd0;
      bus.RtData   = 32'd0;
      bus.OutReady = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("rstInReady", {31'd0, bus.InReady}, 32'd1);
      checkOutput("rstOutValid", {31'd0, bus.OutValid}, 32'd0);
      checkOutput("rstResult", bus.Result, 32'd0);
      checkOutput("rstZero", {31'd0, bus.ZeroFlag}, 32'd0);
      checkOutput("rstDest", {27'd0, bus.DestReg}, 32'd0);
      checkOutput("rstIllegal", {31'd0, bus.Illegal}, 32'd0);
      checkOutput("rstAluCtrl", {28'd0, bus.AluCtrl}, 32'd0);
      Reset = 1'b0;
      @(posedge Clk); #1;

      // add $10 = $8 + $9
      applyStimulus(32'h01095020, 32'd5, 32'd7, 4'h0, 32'd5, 32'd7, 32'd12, 1'b0, 5'd10, 1'b0, 0, 1'b0);
      // slti with imm -1 sign-extended
      applyStimulus(32'h2928FFFF, 32'hFFFFFFFE, 32'h12345678, 4'h2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd8, 1'b0, 0, 1'b0);
      // sll by 4
      applyStimulus(32'h00094100, 32'h0000DEAD, 32'd1, 4'h7, 32'd4, 32'd1, 32'h10, 1'b0, 5'd8, 1'b0, 0, 1'b0);
      // andi zero-extends its immediate
      applyStimulus(32'h3128FFFF, 32'h12345678, 32'd0, 4'h3, 32'h12345678, 32'h0000FFFF, 32'h5678, 1'b0, 5'd8, 1'b0, 0, 1'b0);
      // all-zero word is a legal sll
      applyStimulus(32'h00000000, 32'h11111111, 32'd0, 4'h7, 32'd0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 0, 1'b0);
      // sub with equal operands, held under backpressure for 5 cycles
      applyStimulus(32'h00221822, 32'd10, 32'd10, 4'h1, 32'd10, 32'd10, 32'd0, 1'b1, 5'd3, 1'b0, 5, 1'b0);
      // srl by 8
      applyStimulus(32'h00021A02, 32'd0, 32'h80000000, 4'h8, 32'd8, 32'h80000000, 32'h00800000, 1'b0, 5'd3, 1'b0, 0, 1'b0);
      // ori with high immediate bit still zero-extended
      applyStimulus(32'h35288001, 32'h00010000, 32'd0, 4'h4, 32'h00010000, 32'h00008001, 32'h00018001, 1'b0, 5'd8, 1'b0, 0, 1'b0);
      // addi with negative immediate
      applyStimulus(32'h2128FFFE, 32'd5, 32'd0, 4'h0, 32'd5, 32'hFFFFFFFE, 32'd3, 1'b0, 5'd8, 1'b0, 0, 1'b0);
      // xor, nor, signed slt
      applyStimulus(32'h00221826, 32'hF0F0F0F0, 32'hFF00FF00, 4'h6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 5'd3, 1'b0, 0, 1'b0);
      applyStimulus(32'h00221827, 32'h0F0F0000, 32'h000000FF, 4'h5, 32'h0F0F0000, 32'h000000FF, 32'hF0F0FF00, 1'b0, 5'd3, 1'b0, 0, 1'b0);
      applyStimulus(32'h0022182A, 32'hFFFFFFFF, 32'd1, 4'h2, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 5'd3, 1'b0, 0, 1'b0);
      // xori zero-extension
      applyStimulus(32'h39288000, 32'hFFFF8000, 32'd0, 4'h6, 32'hFFFF8000, 32'h00008000, 32'hFFFF0000, 1'b0, 5'd8, 1'b0, 0, 1'b0);
      // undecodable opcode
      applyStimulus(32'hFC000000, 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b1, 0, 1'b0);
`ifdef ALU_ISSUE_MUL_EN
      applyStimulus(32'h71095002, 32'd3, 32'd4, 4'h9, 32'd3, 32'd4, 32'd12, 1'b0, 5'd10, 1'b0, 0, 1'b0);
`else
      applyStimulus(32'h71095002, 32'd3, 32'd4, 4'h0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b1, 0, 1'b0);
`endif
      // reset while the result is being held
      applyStimulus(32'h01095020, 32'd100, 32'd23, 4'h0, 32'd100, 32'd23, 32'd123, 1'b0, 5'd10, 1'b0, 0, 1'b1);

      // reset while an operation is in EXEC: nothing must come out
      bus.InValid = 1'b1;
      bus.Instr   = 32'h01095020;
      bus.RsData  = 32'd1;
      bus.RtData  = 32'd2;
      @(posedge Clk); #1;
      bus.InValid = 1'b0;
      checkOutput("preRstExecInReady", {31'd0, bus.InReady}, 32'd0);
      Reset = 1'b1;
      #1;
      checkOutput("rstExecOutValid", {31'd0, bus.OutValid}, 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(posedge Clk); #1;
      checkOutput("rstExecInReady", {31'd0, bus.InReady}, 32'd1);
      checkOutput("rstExecNoOutput", {31'd0, bus.OutValid}, 32'd0);

      // a normal operation still works after the aborted one
      applyStimulus(32'h01095020, 32'd40, 32'd2, 4'h0, 32'd40, 32'd2, 32'd42, 1'b0, 5'd10, 1'b0, 1, 1'b0);

      for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge Clk);
      checkOutput("scoreboardDrained", expQ.size(), 32'd0);
      repeat (2) @(posedge Clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock, rising edge; Reset  in  1  asynchronous, active-high.
REQ-002 SHALL have: InValid  in  1  instruction+operands offered; InReady  out  1  unit can accept.
REQ-003 SHALL have: Instr  in  32  MIPS instruction word; RsData  in  32  rs operand; RtData  in  32  rt operand.
REQ-004 SHALL have: AluCtrl  out  4  ALU op select; AluA  out  32  ALU port A; AluB  out  32  ALU port B.
REQ-005 SHALL have: AluResult  in  32  ALU result; AluZero  in  1  ALU zero flag.
REQ-006 SHALL have: OutValid  out  1  result held; OutReady  in  1  consumer accepts.
REQ-007 SHALL have: Result  out  32  captured result; ZeroFlag  out  1  captured zero; DestReg  out  5  destination register; Illegal  out  1  undecodable instruction.

Function
REQ-008 SHALL implement FSM IDLE -> EXEC -> HOLD -> IDLE; InReady=1 only in IDLE.
REQ-009 SHALL accept on rising edge with IDLE and InValid=1, registering Instr, RsData, RtData; go to EXEC.
REQ-010 SHALL, in EXEC, drive AluCtrl/AluA/AluB from registered values only, capture AluResult/AluZero at end of cycle, go to HOLD.
REQ-011 SHALL assert OutValid throughout HOLD with Result/ZeroFlag/DestReg/Illegal stable; leave HOLD to IDLE on edge with OutReady=1.
REQ-012 SHALL give latency 2 cycles accept-edge to OutValid; minimum 3 cycles per operation; no back-to-back acceptance from HOLD.
REQ-013 SHALL drive AluCtrl=0000, AluA=0, AluB=0 outside EXEC.
REQ-014 SHALL encode AluCtrl: 0000 add, 0001 sub, 0010 slt, 0011 and, 0100 or, 0101 nor, 0110 xor, 0111 sll, 1000 srl, 1001 mul.
REQ-015 SHALL decode opcode 0x00 by funct: 0x20 add, 0x22 sub, 0x2A slt, 0x24 and, 0x25 or, 0x27 nor, 0x26 xor, 0x00 sll, 0x02 srl; A=rs, B=rt, DestReg=rd.
REQ-016 SHALL, for sll/srl, drive AluA={27'b0,shamt}, AluB=rt (ALU shifts B by A).
REQ-017 SHALL decode I-type: 0x08 addi, 0x0A slti (imm sign-extended); 0x0C andi, 0x0D ori, 0x0E xori (imm zero-extended); A=rs, B=extended imm, DestReg=rt.
REQ-018 SHALL treat Instr=0x00000000 as legal sll (result 0, ZeroFlag=1).
REQ-019 SHALL, for any other encoding, set Illegal=1, AluCtrl=0000, operands 0, Result=0, ZeroFlag=1, DestReg=0, still traversing EXEC and HOLD.
REQ-020 SHALL ignore InValid outside IDLE and ignore OutReady outside HOLD.

Reset
REQ-021 SHALL on Reset=1, regardless of clock or state, enter IDLE, drop OutValid, clear Result, ZeroFlag, DestReg, Illegal and held operands to 0.
REQ-022 SHALL discard any in-flight operation when reset mid-EXEC or mid-HOLD; InReady=1 in first cycle after release.

Configuration
REQ-023 SHALL, with ALU_ISSUE_MUL_EN defined, decode opcode 0x1C funct 0x02 (mul) to AluCtrl=1001, A=rs, B=rt, DestReg=rd.
REQ-024 SHALL, without ALU_ISSUE_MUL_EN, treat that encoding as illegal per REQ-019 and never emit AluCtrl=1001.

Structure
REQ-025 SHALL place AluCtrl encodings, opcode/funct constants and FSM state encoding in shared package alu_pkg.
REQ-026 SHALL isolate instruction decode in combinational sub-module alu_ctrl_decode (Instr -> AluCtrl, operand selects, extension mode, DestReg, Illegal).

Verification
REQ-027 SHALL cover add: Instr=0x01095020, Rs=5, Rt=7 -> AluCtrl=0000 in EXEC, Result=12, DestReg=10, OutValid 2 cycles after accept.
REQ-028 SHALL cover slti sign-extension: Instr=0x2928FFFF (imm -1), Rs=0xFFFFFFFE -> AluB=0xFFFFFFFF, AluCtrl=0010, DestReg=8.
REQ-029 SHALL cover sll: Instr=0x00094100 (shamt 4), Rt=0x1 -> AluA=4, AluB=1, Result=0x10; andi 0x3128FFFF -> AluB=0x0000FFFF.
REQ-030 SHALL cover backpressure: OutReady=0 for 5 cycles -> OutValid and Result stable, InReady=0; OutReady=1 -> IDLE next cycle.
REQ-031 SHALL cover Reset asserted mid-HOLD -> OutValid=0 immediately, Result=0, InReady=1 after release.
REQ-032 SHALL cover Instr=0x71095002 with/without ALU_ISSUE_MUL_EN -> Rs=3, Rt=4 gives Result=12, Illegal=0 / Illegal=1, Result=0.
